// File: rtl/md_pos_cache.sv
// Per-cell particle position cache: init fill, dirty-tracked broadcast to the force pipeline,
// then random-read / sequential-rewrite service for the motion-update unit.
module md_pos_cache #(
  parameter int unsigned PARTICLE_ID_WIDTH    = 8,
  parameter int unsigned OFFSET_WIDTH         = 23,
  parameter int unsigned ELEMENT_WIDTH        = 2,
  parameter int unsigned GLOBAL_CELL_ID_WIDTH = 3,
  parameter logic [3*GLOBAL_CELL_ID_WIDTH-1:0] CELL_GCID = '0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_PE_start,
  input  logic                                    i_MU_start,
  input  logic                                    i_MU_working,
  input  logic [PARTICLE_ID_WIDTH-1:0]            i_init_wr_addr,
  input  logic [3*OFFSET_WIDTH-1:0]               i_init_data,
  input  logic [ELEMENT_WIDTH-1:0]                i_init_element,
  input  logic                                    i_init_wr_en,
  input  logic                                    i_dirty,
  input  logic [PARTICLE_ID_WIDTH-1:0]            i_MU_rd_addr,
  input  logic                                    i_MU_rd_en,
  input  logic                                    i_MU_wr_en,
  input  logic [3*OFFSET_WIDTH-1:0]               i_MU_wr_pos,
  input  logic [ELEMENT_WIDTH-1:0]                i_MU_wr_element,
  output logic [ELEMENT_WIDTH+3*OFFSET_WIDTH-1:0] o_pos_pkt,
  output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]       o_cur_gcid,
  output logic                                    o_valid,
  output logic                                    o_MU_offset_valid,
  output logic                                    o_dirty,
  output logic [PARTICLE_ID_WIDTH-1:0]            o_debug_num_particles,
  output logic                                    o_debug_all_dirty,
  output logic [3:0]                              o_debug_state
);

  localparam int unsigned Depth = 1 << PARTICLE_ID_WIDTH;
  localparam int unsigned PktW  = ELEMENT_WIDTH + 3 * OFFSET_WIDTH;
  localparam int unsigned CntW  = PARTICLE_ID_WIDTH + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBcast = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StMu    = 2'd3;

  logic [PktW-1:0]              mem [Depth];
  logic [PktW-1:0]              rd_data_q;
  logic [Depth-1:0]             dirty_q, dirty_d;
  logic [1:0]                   state_q, state_d;
  logic [CntW-1:0]              count_q, count_d;
  logic [CntW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PARTICLE_ID_WIDTH-1:0] bptr_q, bptr_d;
  logic [PARTICLE_ID_WIDTH-1:0] out_addr_q;
  logic                         bvld_q, mu_vld_q, mu_work_q;
  logic                         mu_wr_seen_q, mu_wr_seen_d;

  logic                         all_dirty;
  logic                         bcast_valid;
  logic                         mem_we, ram_re;
  logic [PARTICLE_ID_WIDTH-1:0] mem_waddr, ram_raddr;
  logic [PktW-1:0]              mem_wdata;
  logic [CntW-1:0]              init_end;

  // Only entries below the particle count take part in the all-dirty test.
  always_comb begin
    all_dirty = 1'b1;
    for (int unsigned i = 0; i < Depth; i++) begin
      if ((CntW'(i) < count_q) && !dirty_q[i]) all_dirty = 1'b0;
    end
  end

  assign bcast_valid = (state_q == StBcast) && bvld_q && !dirty_q[out_addr_q];
  assign init_end    = {1'b0, i_init_wr_addr} + CntW'(1);

  // RAM port steering by phase.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_init_wr_addr;
    mem_wdata = {i_init_element, i_init_data};
    ram_re    = 1'b0;
    ram_raddr = bptr_q;
    unique case (state_q)
      StIdle:  mem_we = i_init_wr_en;
      StBcast: ram_re = 1'b1;
      StMu: begin
        ram_re    = i_MU_rd_en;
        ram_raddr = i_MU_rd_addr;
        mem_we    = i_MU_wr_en;
        mem_waddr = wr_ptr_q[PARTICLE_ID_WIDTH-1:0];
        mem_wdata = {i_MU_wr_element, i_MU_wr_pos};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Non-blocking read of the old word gives read-first behaviour on address collisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (ram_re) begin
      rd_data_q <= mem[ram_raddr];
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    dirty_d      = dirty_q;
    bptr_d       = bptr_q;
    wr_ptr_d     = wr_ptr_q;
    mu_wr_seen_d = mu_wr_seen_q;
    unique case (state_q)
      StIdle: begin
        if (i_init_wr_en && (init_end > count_q)) count_d = init_end;
        if (i_PE_start) begin
          state_d = StBcast;
          bptr_d  = '0;
        end
      end
      StBcast: begin
        if (bcast_valid && i_dirty) dirty_d[out_addr_q] = 1'b1;
        if (({1'b0, bptr_q} + CntW'(1)) >= count_q) bptr_d = '0;
        else bptr_d = bptr_q + 1'b1;
        if (all_dirty) state_d = StDone;
      end
      StDone: begin
        if (i_MU_start) begin
          state_d      = StMu;
          wr_ptr_d     = '0;
          mu_wr_seen_d = 1'b0;
        end
      end
      StMu: begin
        if (i_MU_wr_en) begin
          wr_ptr_d     = wr_ptr_q + CntW'(1);
          mu_wr_seen_d = 1'b1;
        end
        if (mu_work_q && !i_MU_working) begin
          if (mu_wr_seen_d) count_d = wr_ptr_d;
          dirty_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      dirty_q      <= '0;
      bptr_q       <= '0;
      wr_ptr_q     <= '0;
      mu_wr_seen_q <= 1'b0;
      out_addr_q   <= '0;
      bvld_q       <= 1'b0;
      mu_vld_q     <= 1'b0;
      mu_work_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      dirty_q      <= dirty_d;
      bptr_q       <= bptr_d;
      wr_ptr_q     <= wr_ptr_d;
      mu_wr_seen_q <= mu_wr_seen_d;
      out_addr_q   <= (state_q == StBcast) ? bptr_q : out_addr_q;
      bvld_q       <= (state_q == StBcast) && !all_dirty;
      mu_vld_q     <= (state_q == StMu) && i_MU_rd_en;
      mu_work_q    <= i_MU_working;
    end
  end

  assign o_pos_pkt             = rd_data_q;
  assign o_cur_gcid            = CELL_GCID;
  assign o_valid               = bcast_valid;
  assign o_MU_offset_valid     = mu_vld_q;
  assign o_dirty               = (state_q == StDone) || (state_q == StMu);
  assign o_debug_num_particles = count_q[PARTICLE_ID_WIDTH-1:0];
  assign o_debug_all_dirty     = all_dirty && (count_q != '0);
  assign o_debug_state         = {2'b00, state_q};

endmodule

// File: tb/tb_md_pos_cache.sv
// Directed bench for md_pos_cache: transaction-level model compared every cycle plus literal pins.
module tb_md_pos_cache;

  localparam int PW = 8;
  localparam int OW = 23;
  localparam int EW = 2;
  localparam int KW = EW + 3 * OW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_PE_start = 0, i_MU_start = 0, i_MU_working = 0;
  logic [PW-1:0] i_init_wr_addr = '0;
  logic [3*OW-1:0] i_init_data = '0;
  logic [EW-1:0] i_init_element = '0;
  logic          i_init_wr_en = 0, i_dirty = 0;
  logic [PW-1:0] i_MU_rd_addr = '0;
  logic          i_MU_rd_en = 0, i_MU_wr_en = 0;
  logic [3*OW-1:0] i_MU_wr_pos = '0;
  logic [EW-1:0] i_MU_wr_element = '0;
  logic [KW-1:0] o_pos_pkt;
  logic [8:0]    o_cur_gcid;
  logic          o_valid, o_MU_offset_valid, o_dirty, o_debug_all_dirty;
  logic [PW-1:0] o_debug_num_particles;
  logic [3:0]    o_debug_state;

  md_pos_cache dut (
    .clk(clk), .rst(rst), .i_PE_start(i_PE_start), .i_MU_start(i_MU_start),
    .i_MU_working(i_MU_working), .i_init_wr_addr(i_init_wr_addr), .i_init_data(i_init_data),
    .i_init_element(i_init_element), .i_init_wr_en(i_init_wr_en), .i_dirty(i_dirty),
    .i_MU_rd_addr(i_MU_rd_addr), .i_MU_rd_en(i_MU_rd_en), .i_MU_wr_en(i_MU_wr_en),
    .i_MU_wr_pos(i_MU_wr_pos), .i_MU_wr_element(i_MU_wr_element), .o_pos_pkt(o_pos_pkt),
    .o_cur_gcid(o_cur_gcid), .o_valid(o_valid), .o_MU_offset_valid(o_MU_offset_valid),
    .o_dirty(o_dirty), .o_debug_num_particles(o_debug_num_particles),
    .o_debug_all_dirty(o_debug_all_dirty), .o_debug_state(o_debug_state)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [KW-1:0] m_mem [256];
  bit            m_dirty [256];
  int            m_st, m_cnt, m_ptr, m_addr, m_wp;
  bit            m_seen, m_bvld, m_muvld, m_prev_work;
  logic [KW-1:0] m_pkt;

  function automatic bit m_all_dirty();
    for (int i = 0; i < m_cnt; i++) if (!m_dirty[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_valid();
    return (m_st == 1) && m_bvld && !m_dirty[m_addr];
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_ptr = 0; m_addr = 0; m_wp = 0;
    m_seen = 0; m_bvld = 0; m_muvld = 0; m_prev_work = 0; m_pkt = '0;
    for (int i = 0; i < 256; i++) m_dirty[i] = 0;
  endtask

  task automatic model_step();
    bit alld, v, nb, nm;
    alld = m_all_dirty();
    v = m_valid();
    nb = 0; nm = 0;
    case (m_st)
      0: begin
        if (i_init_wr_en) begin
          m_mem[i_init_wr_addr] = {i_init_element, i_init_data};
          if (int'(i_init_wr_addr) + 1 > m_cnt) m_cnt = int'(i_init_wr_addr) + 1;
        end
        if (i_PE_start) begin m_st = 1; m_ptr = 0; end
      end
      1: begin
        if (v && i_dirty) m_dirty[m_addr] = 1;
        m_pkt = m_mem[m_ptr];
        m_addr = m_ptr;
        nb = !alld;
        m_ptr = (m_ptr + 1 >= m_cnt) ? 0 : m_ptr + 1;
        if (alld) m_st = 2;
      end
      2: if (i_MU_start) begin m_st = 3; m_wp = 0; m_seen = 0; end
      default: begin
        if (i_MU_rd_en) begin m_pkt = m_mem[i_MU_rd_addr]; nm = 1; end
        if (i_MU_wr_en) begin
          m_mem[m_wp] = {i_MU_wr_element, i_MU_wr_pos};
          m_wp++; m_seen = 1;
        end
        if (m_prev_work && !i_MU_working) begin
          if (m_seen) m_cnt = m_wp;
          for (int i = 0; i < 256; i++) m_dirty[i] = 0;
          m_st = 0;
        end
      end
    endcase
    m_bvld = nb; m_muvld = nm; m_prev_work = i_MU_working;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_step();
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("pkt", 80'(o_pos_pkt), 80'(m_pkt));
      check("valid", 80'(o_valid), 80'(m_valid()));
      check("mu_valid", 80'(o_MU_offset_valid), 80'(m_muvld));
      check("dirty", 80'(o_dirty), 80'(m_st == 2 || m_st == 3));
      check("all_dirty", 80'(o_debug_all_dirty), 80'(m_cnt != 0 && m_all_dirty()));
      check("num", 80'(o_debug_num_particles), 80'(m_cnt % 256));
      check("state", 80'(o_debug_state), 80'(m_st));
      check("gcid", 80'(o_cur_gcid), 80'(0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [KW-1:0] entry(input int k);
    logic [OW-1:0] off;
    off = OW'(k * 'h80000);
    if (k == 0) return {2'd0, 23'd15, 46'd0};
    return {2'd1, off, off, off};
  endfunction

  function automatic logic [KW-1:0] new_entry(input int j);
    logic [OW-1:0] off;
    off = OW'((j + 1) * 'h1000);
    return {2'd2, off, off, off};
  endfunction

  task automatic wait_done(input string name);
    for (int c = 0; c < 100 && !o_dirty; c++) tick();
    check(name, 80'(o_dirty), 80'(1));
  endtask

  initial begin
    logic [KW-1:0] exp3;
    int idx;
    tick(); tick();
    check("rst_state", 80'(o_debug_state), 80'(0));
    check("rst_pkt", 80'(o_pos_pkt), 80'(0));
    rst = 1'b1;
    tick();

    // 1: init 16 entries
    for (int k = 0; k < 16; k++) begin
      i_init_wr_addr = PW'(k);
      i_init_data    = entry(k)[3*OW-1:0];
      i_init_element = entry(k)[KW-1:3*OW];
      i_init_wr_en   = 1'b1;
      tick();
    end
    i_init_wr_en = 1'b0;
    tick();
    check("init_num", 80'(o_debug_num_particles), 80'(16));
    check("init_state", 80'(o_debug_state), 80'(0));

    // 2: broadcast start
    i_PE_start = 1'b1;
    tick();
    check("bcast_state", 80'(o_debug_state), 80'(1));
    tick();
    check("bcast_first_valid", 80'(o_valid), 80'(1));
    check("bcast_first_pkt", 80'(o_pos_pkt), 80'({2'd0, 23'd15, 46'd0}));

    // 3: consume 0..14, let 15 re-stream, then consume it
    i_dirty = 1'b1;
    for (int c = 0; c < 15; c++) tick();
    i_dirty = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (o_valid) check("only_15_restreams", 80'(o_pos_pkt), 80'(entry(15)));
    end
    i_dirty = 1'b1;
    wait_done("wait_all_dirty");
    i_dirty = 1'b0;
    i_PE_start = 1'b0;
    check("done_all_dirty", 80'(o_debug_all_dirty), 80'(1));
    check("done_state", 80'(o_debug_state), 80'(2));

    // 4: MU reads
    i_MU_working = 1'b1;
    i_MU_start = 1'b1;
    tick();
    i_MU_start = 1'b0;
    check("mu_state", 80'(o_debug_state), 80'(3));
    for (int a = 0; a < 7; a++) begin
      i_MU_rd_addr = PW'(a);
      i_MU_rd_en = 1'b1;
      tick();
      check("mu_rd_valid", 80'(o_MU_offset_valid), 80'(1));
      check("mu_rd_pkt", 80'(o_pos_pkt), 80'(entry(a)));
    end
    exp3 = {2'd1, 23'h180000, 23'h180000, 23'h180000};
    check("mu_addr3_literal", 80'(entry(3)), 80'(exp3));
    i_MU_rd_en = 1'b0;
    i_MU_working = 1'b0;
    tick();
    check("mu_exit_state", 80'(o_debug_state), 80'(0));
    check("mu_exit_dirty", 80'(o_dirty), 80'(0));
    check("mu_exit_num", 80'(o_debug_num_particles), 80'(16));

    // 5: second round, rewrite 5 entries
    i_PE_start = 1'b1;
    i_dirty = 1'b1;
    tick();
    wait_done("wait_round2");
    i_PE_start = 1'b0;
    i_dirty = 1'b0;
    i_MU_working = 1'b1;
    i_MU_start = 1'b1;
    tick();
    i_MU_start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      i_MU_wr_en = 1'b1;
      i_MU_wr_pos = new_entry(j)[3*OW-1:0];
      i_MU_wr_element = 2'd2;
      tick();
    end
    i_MU_wr_en = 1'b0;
    i_MU_working = 1'b0;
    tick();
    check("mu_wr_num", 80'(o_debug_num_particles), 80'(5));
    i_PE_start = 1'b1;
    tick();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_valid) begin
        check("new_stream_pkt", 80'(o_pos_pkt), 80'(new_entry(idx % 5)));
        idx++;
      end
    end
    check("new_stream_count", 80'(idx), 80'(20));

    // 6: async reset mid-broadcast
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_state", 80'(o_debug_state), 80'(0));
    check("arst_num", 80'(o_debug_num_particles), 80'(0));
    check("arst_valid", 80'(o_valid), 80'(0));
    check("arst_pkt", 80'(o_pos_pkt), 80'(0));
    i_PE_start = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
